// File: rtl/sample_clock_monitor_if.sv
// Signal bundle between the sample-clock monitor and its consumer:
// the raw sample clock in, and the tick / period / lock status out.
interface sample_clock_monitor_if;
  logic        clk_sample;
  logic        sample_tick;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  modport master (
    input  clk_sample,
    output sample_tick,
    output period,
    output period_valid,
    output locked,
    output timeout
  );

  modport slave (
    output clk_sample,
    input  sample_tick,
    input  period,
    input  period_valid,
    input  locked,
    input  timeout
  );
endinterface

// File: rtl/sample_clock_monitor.sv
// Synchronises an asynchronous sample clock into clk_in, emits one tick per
// rising edge, measures each period and tracks lock / loss of the clock.
module sample_clock_monitor #(
  parameter int unsigned NOMINAL_PERIOD = 1133,
  parameter int unsigned TOLERANCE      = 4,
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4532
) (
  input  logic                   clk_in,
  input  logic                   reset,
  sample_clock_monitor_if.master mon
);

  localparam logic [31:0] LO_BOUND = 32'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [31:0] HI_BOUND = 32'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [31:0] CNT_MAX  = 32'(TIMEOUT_CYCLES - 1);
  localparam int unsigned GW       = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          tick_q, tick_d;
  logic [31:0]   period_q, period_d;
  logic          pv_q, pv_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  logic          edge_hit;
  logic [31:0]   meas;
  logic          in_tol;

  always_comb begin
    s1_d = mon.clk_sample;
    s2_d = s1_q;
    s3_d = s2_q;
    // The zeros loaded into s1/s2 by reset are not real samples; only a low
    // that actually came through the synchroniser may arm edge detection.
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);

    edge_hit = s2_q & ~s3_q & armed_q;
    meas     = cnt_q + 32'd1;
    in_tol   = (meas >= LO_BOUND) && (meas <= HI_BOUND);

    if (edge_hit)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 32'd1;

    state_d   = state_q;
    good_d    = good_q;
    tick_d    = edge_hit;
    period_d  = period_q;
    pv_d      = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    case (state_q)
      SEARCH: begin
        if (edge_hit) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (edge_hit) begin
          period_d = meas;
          pv_d     = 1'b1;
          if (in_tol) begin
            if (good_q + GW'(1) == LOCK_TARGET) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
            good_d = good_q + GW'(1);
          end else begin
            good_d = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d   = SEARCH;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          period_d  = '0;
        end
      end
      LOCKED: begin
        if (edge_hit) begin
          period_d = meas;
          pv_d     = 1'b1;
          if (!in_tol) begin
            state_d  = ACQUIRE;
            locked_d = 1'b0;
            good_d   = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d   = SEARCH;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          period_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= SEARCH;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      good_q    <= '0;
      tick_q    <= 1'b0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign mon.sample_tick  = tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.locked       = locked_q;
  assign mon.timeout      = timeout_q;

endmodule

// File: tb/tb_sample_clock_monitor.sv
// Directed bench for sample_clock_monitor: lock, tolerance, glitch, loss of
// clock, high level at reset release and reset during acquisition.
module tb_sample_clock_monitor;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  sample_clock_monitor_if mon ();

  sample_clock_monitor #(
    .NOMINAL_PERIOD (1133),
    .TOLERANCE      (4),
    .LOCK_COUNT     (8),
    .TIMEOUT_CYCLES (4532)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .mon    (mon)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Event recorder, sampled on the falling edge.
  int cyc = 0;
  int tick_cnt = 0, pv_cnt = 0, bad_cnt = 0, to_cnt = 0;
  int rise_cnt = 0, rise_tick = 0, fall_cnt = 0, wide_cnt = 0;
  int last_tick_cyc = 0, to_cyc = 0;
  int exp_period = 0;
  logic        rise_with_tick = 1'b0, fall_with_pv = 1'b0;
  logic [31:0] fall_period = '0, to_period = '0;
  logic        to_locked = 1'b0, to_pv = 1'b0;
  logic        prev_locked = 1'b0, prev_tick = 1'b0, prev_pv = 1'b0, prev_to = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (mon.sample_tick === 1'b1) begin
      tick_cnt++;
      last_tick_cyc = cyc;
      if (prev_tick) wide_cnt++;
    end
    if (mon.period_valid === 1'b1) begin
      pv_cnt++;
      if (mon.period !== 32'(exp_period)) bad_cnt++;
      if (prev_pv) wide_cnt++;
    end
    if (mon.timeout === 1'b1) begin
      to_cnt++;
      to_cyc    = cyc;
      to_locked = mon.locked;
      to_period = mon.period;
      to_pv     = mon.period_valid;
      if (prev_to) wide_cnt++;
    end
    if (mon.locked === 1'b1 && !prev_locked) begin
      rise_cnt++;
      rise_tick      = tick_cnt;
      rise_with_tick = mon.sample_tick;
    end
    if (mon.locked === 1'b0 && prev_locked) begin
      fall_cnt++;
      fall_period  = mon.period;
      fall_with_pv = mon.period_valid;
    end
    prev_locked = (mon.locked === 1'b1);
    prev_tick   = (mon.sample_tick === 1'b1);
    prev_pv     = (mon.period_valid === 1'b1);
    prev_to     = (mon.timeout === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_periods(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      mon.clk_sample = 1'b1;
      cycles(per / 2);
      mon.clk_sample = 1'b0;
      cycles(per - per / 2);
    end
  endtask

  task automatic apply_reset(input logic level);
    @(negedge clk_in);
    reset = 1'b1;
    mon.clk_sample = level;
    cycles(3);
    reset = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    reset = 1'b1;
    mon.clk_sample = 1'b0;
    cycles(3);
    checks++; if (mon.sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", mon.sample_tick); end
    checks++; if (mon.period !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", mon.period); end
    checks++; if (mon.period_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b expected 0", mon.period_valid); end
    checks++; if (mon.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", mon.locked); end
    checks++; if (mon.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", mon.timeout); end
    reset = 1'b0;
    cycles(4);
  endtask

  task automatic test_high_at_reset;
    int base_t, base_pv;
    @(negedge clk_in);
    reset = 1'b1;
    mon.clk_sample = 1'b1;
    cycles(3);
    reset = 1'b0;
    base_t = tick_cnt; base_pv = pv_cnt;
    cycles(20);
    checks++; if (tick_cnt - base_t !== 0) begin errors++; $display("FAIL high_release_tick: got %0d ticks expected 0", tick_cnt - base_t); end
    mon.clk_sample = 1'b0;
    cycles(10);
    checks++; if (tick_cnt - base_t !== 0) begin errors++; $display("FAIL high_low_tick: got %0d ticks expected 0", tick_cnt - base_t); end
    mon.clk_sample = 1'b1;
    cycles(5);
    checks++; if (tick_cnt - base_t !== 1) begin errors++; $display("FAIL high_rearm_tick: got %0d ticks expected 1", tick_cnt - base_t); end
    checks++; if (pv_cnt - base_pv !== 0) begin errors++; $display("FAIL high_rearm_pv: got %0d expected 0", pv_cnt - base_pv); end
    mon.clk_sample = 1'b0;
    cycles(5);
  endtask

  task automatic test_nominal_lock;
    int base_t, base_pv, base_bad, base_rise;
    apply_reset(1'b0);
    exp_period = 1133;
    base_t = tick_cnt; base_pv = pv_cnt; base_bad = bad_cnt; base_rise = rise_cnt;
    mon.clk_sample = 1'b1;
    cycles(2);
    checks++; if (mon.sample_tick !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", mon.sample_tick); end
    cycles(1);
    checks++; if (mon.sample_tick !== 1'b1) begin errors++; $display("FAIL latency_tick: got %b expected 1", mon.sample_tick); end
    checks++; if (mon.period_valid !== 1'b0) begin errors++; $display("FAIL first_edge_pv: got %b expected 0", mon.period_valid); end
    cycles(566 - 3);
    mon.clk_sample = 1'b0;
    cycles(567);
    drive_periods(8, 1133);
    checks++; if (pv_cnt - base_pv !== 8) begin errors++; $display("FAIL nominal_pv_count: got %0d expected 8", pv_cnt - base_pv); end
    checks++; if (bad_cnt - base_bad !== 0) begin errors++; $display("FAIL nominal_period: got %0d wrong values expected 0", bad_cnt - base_bad); end
    checks++; if (rise_cnt - base_rise !== 1) begin errors++; $display("FAIL nominal_lock_rises: got %0d expected 1", rise_cnt - base_rise); end
    checks++; if (rise_tick - base_t !== 9) begin errors++; $display("FAIL nominal_lock_edge: got %0d expected 9", rise_tick - base_t); end
    checks++; if (rise_with_tick !== 1'b1) begin errors++; $display("FAIL lock_with_tick: got %b expected 1", rise_with_tick); end
    checks++; if (mon.locked !== 1'b1) begin errors++; $display("FAIL nominal_locked: got %b expected 1", mon.locked); end
  endtask

  task automatic test_glitch;
    int base_t, base_fall;
    drive_periods(1, 1120);
    checks++; if (mon.locked !== 1'b1) begin errors++; $display("FAIL glitch_pre_locked: got %b expected 1", mon.locked); end
    base_t = tick_cnt; base_fall = fall_cnt;
    drive_periods(9, 1133);
    checks++; if (fall_cnt - base_fall !== 1) begin errors++; $display("FAIL glitch_falls: got %0d expected 1", fall_cnt - base_fall); end
    checks++; if (fall_period !== 32'd1120) begin errors++; $display("FAIL glitch_period: got %0d expected 1120", fall_period); end
    checks++; if (fall_with_pv !== 1'b1) begin errors++; $display("FAIL glitch_pv: got %b expected 1", fall_with_pv); end
    checks++; if (rise_tick - base_t !== 9) begin errors++; $display("FAIL glitch_relock_edge: got %0d expected 9", rise_tick - base_t); end
    checks++; if (mon.locked !== 1'b1) begin errors++; $display("FAIL glitch_relocked: got %b expected 1", mon.locked); end
  endtask

  task automatic test_loss;
    int base_to, base_t, base_pv;
    base_to = to_cnt;
    for (int i = 0; i < 6000 && to_cnt == base_to; i++) cycles(1);
    checks++; if (to_cnt - base_to !== 1) begin errors++; $display("FAIL timeout_seen: got %0d expected 1", to_cnt - base_to); end
    checks++; if (to_cyc - last_tick_cyc !== 4532) begin errors++; $display("FAIL timeout_delay: got %0d expected 4532", to_cyc - last_tick_cyc); end
    checks++; if (to_locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %b expected 0", to_locked); end
    checks++; if (to_period !== 32'd0) begin errors++; $display("FAIL timeout_period: got %0d expected 0", to_period); end
    checks++; if (to_pv !== 1'b0) begin errors++; $display("FAIL timeout_pv: got %b expected 0", to_pv); end
    cycles(20);
    exp_period = 1133;
    base_t = tick_cnt; base_pv = pv_cnt;
    drive_periods(9, 1133);
    checks++; if (tick_cnt - base_t !== 9) begin errors++; $display("FAIL resume_ticks: got %0d expected 9", tick_cnt - base_t); end
    checks++; if (pv_cnt - base_pv !== 8) begin errors++; $display("FAIL resume_pv: got %0d expected 8", pv_cnt - base_pv); end
    checks++; if (rise_tick - base_t !== 9) begin errors++; $display("FAIL resume_lock_edge: got %0d expected 9", rise_tick - base_t); end
    checks++; if (mon.locked !== 1'b1) begin errors++; $display("FAIL resume_locked: got %b expected 1", mon.locked); end
  endtask

  task automatic test_out_of_tolerance;
    int base_pv, base_bad, base_rise;
    apply_reset(1'b0);
    exp_period = 1140;
    base_pv = pv_cnt; base_bad = bad_cnt; base_rise = rise_cnt;
    drive_periods(9, 1140);
    checks++; if (pv_cnt - base_pv !== 8) begin errors++; $display("FAIL oot_pv_count: got %0d expected 8", pv_cnt - base_pv); end
    checks++; if (bad_cnt - base_bad !== 0) begin errors++; $display("FAIL oot_period: got %0d wrong values expected 0", bad_cnt - base_bad); end
    checks++; if (rise_cnt - base_rise !== 0) begin errors++; $display("FAIL oot_lock_rises: got %0d expected 0", rise_cnt - base_rise); end
    checks++; if (mon.period !== 32'd1140) begin errors++; $display("FAIL oot_last_period: got %0d expected 1140", mon.period); end
  endtask

  task automatic test_reset_mid;
    int base_t, base_pv, base_bad;
    apply_reset(1'b0);
    drive_periods(5, 1133);
    checks++; if (mon.period !== 32'd1133) begin errors++; $display("FAIL mid_pre_period: got %0d expected 1133", mon.period); end
    mon.clk_sample = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    checks++; if (mon.period !== 32'd0) begin errors++; $display("FAIL mid_reset_period: got %0d expected 0", mon.period); end
    checks++; if (mon.locked !== 1'b0) begin errors++; $display("FAIL mid_reset_locked: got %b expected 0", mon.locked); end
    checks++; if (mon.sample_tick !== 1'b0) begin errors++; $display("FAIL mid_reset_tick: got %b expected 0", mon.sample_tick); end
    checks++; if (mon.period_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_pv: got %b expected 0", mon.period_valid); end
    mon.clk_sample = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(4);
    exp_period = 1137;
    base_t = tick_cnt; base_pv = pv_cnt; base_bad = bad_cnt;
    drive_periods(9, 1137);
    checks++; if (pv_cnt - base_pv !== 8) begin errors++; $display("FAIL mid_after_pv: got %0d expected 8", pv_cnt - base_pv); end
    checks++; if (bad_cnt - base_bad !== 0) begin errors++; $display("FAIL mid_after_period: got %0d wrong values expected 0", bad_cnt - base_bad); end
    checks++; if (rise_tick - base_t !== 9) begin errors++; $display("FAIL tol_edge_lock_edge: got %0d expected 9", rise_tick - base_t); end
    checks++; if (mon.locked !== 1'b1) begin errors++; $display("FAIL tol_edge_locked: got %b expected 1", mon.locked); end
  endtask

  task automatic test_pulse_width;
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); end
  endtask

  initial begin
    mon.clk_sample = 1'b0;
    test_reset();
    test_high_at_reset();
    test_nominal_lock();
    test_glitch();
    test_loss();
    test_out_of_tolerance();
    test_reset_mid();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles", cyc);
    $fatal(1, "time limit");
  end

endmodule
